seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
// PURPOSE
//   Sequential radix-2 shift-and-add unsigned multiplier: one partial product per clock.
//   Built from a 64-bit left barrel shifter on A, a 32-bit right barrel shifter on B,
//   a 64-bit AND gate, an adder and a 64-bit accumulator register.
//   Sits in the FPU datapath as the mantissa/integer multiply unit.
// PARAMETERS
//   N  32  operand width; accumulator 2N bits, counter clog2(N)+1 bits, res 2N+1 bits
// PORTS
//   clk     in   1     rising-edge clock
//   reset   in   1     synchronous, active-high; also acts as "start"
//   opA     in   N     multiplicand, unsigned; hold stable from reset release until res_ok
//   opB     in   N     multiplier, unsigned; hold stable from reset release until res_ok
//   res     out  2N+1  product = accumulator zero-extended; res[2N] is always 0
//   res_ok  out  1     result valid (combinational)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset edge: ct <= 0 and acc <= 0. res = 0 in the cycle after reset.
//   - State: counter ct (0..N, saturating) and accumulator acc (2N bits).
//   - Each rising edge with reset low and ct < N:
//       acc <= acc + (opB[ct] ? ({N'b0,opA} << ct) : 0)   (mod 2^2N, carry out ignored)
//       ct  <= ct + 1
//   - When ct == N, ct and acc hold and no further additions occur.
//     The counter never wraps.
//   - Datapath:
//       A_SH   = zero-extend(opA) << ct      (barrel64, logical)
//       B_SH   = opB >> ct                   (barrel32, logical)
//       addend = A_SH & {2N{B_SH[0]}}        (and64)
//   - res_ok = ~|B_SH, i.e. (opB >> ct) == 0. Purely combinational; no register stage.
//   - Latency: res_ok rises msb(opB)+1 cycles after reset release.
//     At that point acc already holds opA*opB. Worst case is N cycles.
//   - opB == 0: res_ok = 1 immediately after reset; res = 0.
//   - opA == 0: the counter still advances; res = 0 throughout.
//   - Reset mid-operation: the partial result is discarded and the multiply restarts
//     from ct = 0 on the next edge.
//   - Changing opA/opB before res_ok gives an undefined result. No error is flagged.
//   - Max product (2^N-1)^2 fits in 2N bits, so no overflow is possible.
// CONFIGURATION
//   MULT_EARLY_DONE_EN defined (default in FPU build):
//     - res_ok = ((opB >> ct) == 0) as above.
//     - Additions also stop once B_SH == 0.
//   MULT_EARLY_DONE_EN undefined:
//     - res_ok = (ct == N), giving a fixed N-cycle latency independent of opB.
//     - Arithmetic is identical.
// TESTING
//   1. reset 1 cycle, opA=78319, opB=54491 -> res_ok at cycle 16 after release;
//      res = 4267680629, stable through cycle 40.
//   2. opA=0xFFFFFFFF, opB=0xFFFFFFFF -> res_ok at cycle 32;
//      res = 0x0_FFFFFFFE_00000001.
//   3. opA=12345, opB=0 -> res_ok=1 on the first cycle after reset; res = 0.
//      Without MULT_EARLY_DONE_EN, res_ok rises at cycle 32.
//   4. opA=1, opB=0x80000000 -> res_ok low for cycles 0..31 and high at 32;
//      res = 0x80000000.
//   5. Start 7*9. At cycle 2 assert reset and switch to opA=3, opB=5
//      -> res_ok at cycle 3 after the second release; res = 15.
//   6. After completion hold 20 extra cycles -> res and res_ok unchanged; ct stays at N.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential radix-2 shift-and-add unsigned multiplier
//
// Purpose:
//   Adds one partial product per clock into a 2N-bit accumulator. The
//   multiplicand is left-shifted by the step count (barrel, logical), the
//   multiplier is right-shifted by the step count. The low bit of the shifted
//   multiplier gates the shifted multiplicand into the adder.
//
// Configuration macro:
//   MULT_EARLY_DONE_EN
//     defined   : res_ok = ((opB >> ct) == 0), so latency is msb(opB)+1 cycles.
//     undefined : res_ok = (ct == N), so latency is a fixed N cycles.
//   The arithmetic is the same in both builds.
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high; also starts a new multiply
//   opA     in   N      multiplicand, unsigned; hold stable until res_ok
//   opB     in   N      multiplier, unsigned; hold stable until res_ok
//   res     out  2N+1   accumulator zero-extended; res[2N] is always 0
//   res_ok  out  1      result valid (combinational)

module seq_shift_add_mult #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   opA,
  input  logic [N-1:0]   opB,
  output logic [2*N:0]   res,
  output logic           res_ok
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CT_MAX = CW'(N);

  logic [CW-1:0]  ct;
  logic [2*N-1:0] acc;

  logic [2*N-1:0] a_sh;
  logic [N-1:0]   b_sh;
  logic [2*N-1:0] addend;
  logic           b_rest_zero;

  // Barrel shifters and the AND gate that selects the partial product.
  assign a_sh        = {{N{1'b0}}, opA} << ct;
  assign b_sh        = opB >> ct;
  assign addend      = a_sh & {(2*N){b_sh[0]}};
  assign b_rest_zero = ~|b_sh;

  // The counter saturates at N and never wraps. The accumulator is only
  // written while multiplier bits remain: once (opB >> ct) is zero every
  // further addend is zero, so stopping early leaves the product unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ct  <= '0;
      acc <= '0;
    end else if (ct != CT_MAX) begin
      ct <= ct + 1'b1;
      if (!b_rest_zero) begin
        acc <= acc + addend;
      end
    end
  end

  assign res = {1'b0, acc};

`ifdef MULT_EARLY_DONE_EN
  assign res_ok = b_rest_zero;
`else
  assign res_ok = (ct == CT_MAX);
`endif

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - directed self-checking bench for seq_shift_add_mult

module tb_seq_shift_add_mult;

  localparam int N = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   opA;
  logic [N-1:0]   opB;
  logic [2*N:0]   res;
  logic           res_ok;

  int checks;
  int failures;

  seq_shift_add_mult #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .opA    (opA),
    .opB    (opB),
    .res    (res),
    .res_ok (res_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*N:0] got, input logic [2*N:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply operands with reset high for one edge; returns #1 after the edge
  // with reset low, i.e. at cycle 0 after release.
  task automatic do_reset(input logic [N-1:0] a, input logic [N-1:0] b);
    reset = 1'b1;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From cycle 0 after release: check reset state, wait (bounded) for res_ok,
  // check the cycle it rose on and the product, then hold and check stability.
  task automatic run_check(input string tag, input logic [2*N:0] exp_res,
                           input int exp_lat, input int hold);
    int k;
    check({tag, "_rst_res"}, res, '0);
    k = 0;
    while (!res_ok && k < 100) begin
      check({tag, "_early_ok"}, {64'd0, res_ok}, '0);
      step();
      k++;
    end
    check({tag, "_latency"}, (2*N+1)'(k), (2*N+1)'(exp_lat));
    check({tag, "_res"}, res, exp_res);
    for (int i = 0; i < hold; i++) begin
      step();
    end
    if (hold > 0) begin
      check({tag, "_hold_ok"}, {64'd0, res_ok}, 65'd1);
      check({tag, "_hold_res"}, res, exp_res);
    end
  endtask

  int lat_full;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    opA      = '0;
    opB      = '0;
    repeat (2) @(posedge clk);
    #1;

`ifdef MULT_EARLY_DONE_EN
    lat_full = 0;
`else
    lat_full = 1;
`endif

    // 78319 * 54491: msb(opB)=15 -> 16 cycles; hold to cycle 40.
    do_reset(32'd78319, 32'd54491);
    run_check("t1", 65'd4267680629, lat_full ? 32 : 16, 40 - (lat_full ? 32 : 16));

    // All ones: max product.
    do_reset(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("t2", 65'h0_FFFF_FFFE_0000_0001, 32, 5);

    // opB == 0.
    do_reset(32'd12345, 32'd0);
    run_check("t3", 65'd0, lat_full ? 32 : 0, 3);

    // Only the top multiplier bit set.
    do_reset(32'd1, 32'h8000_0000);
    run_check("t4", 65'h0_0000_0000_8000_0000, 32, 2);

    // opA == 0 with a busy multiplier: product stays zero.
    do_reset(32'd0, 32'h0000_00FF);
    run_check("t5", 65'd0, lat_full ? 32 : 8, 2);

    // Restart mid-operation: 7*9 for two cycles, then 3*5.
    do_reset(32'd7, 32'd9);
    step();
    step();
    do_reset(32'd3, 32'd5);
    run_check("t6", 65'd15, lat_full ? 32 : 3, 20);

    // Mixed operands: 0xABCD * 0x1234 = 0x0C374FA4, msb(opB)=12 -> 13 cycles.
    do_reset(32'h0000_ABCD, 32'h0000_1234);
    run_check("t7", 65'h0_0000_0000_0C37_4FA4, lat_full ? 32 : 13, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
